// File: rtl/round_arbiter_if.sv
// round_arbiter_if -- player/display bundle of the hex-quiz round scheduler.
// Rev 1.0
`default_nettype none

interface round_arbiter_if;
   logic        start;
   logic [3:0]  guess_valid;
   logic [31:0] guess;
   logic [3:0]  guess_ack;
   logic [7:0]  value;
   logic [15:0] p1;
   logic [15:0] p2;
   logic [15:0] p3;
   logic [15:0] p4;
   logic [1:0]  winner;
   logic        winner_valid;
   logic        game_over;
   logic [2:0]  state;

   modport slave (
      input  start, guess_valid, guess,
      output guess_ack, value, p1, p2, p3, p4, winner, winner_valid, game_over, state
   );

   modport master (
      output start, guess_valid, guess,
      input  guess_ack, value, p1, p2, p3, p4, winner, winner_valid, game_over, state
   );
endinterface

`default_nettype wire

// File: rtl/round_arbiter.sv
// round_arbiter -- issues LFSR targets, round-robin arbitrates four guessers, keeps scores.
// Rev 1.0
`default_nettype none

module round_arbiter #(
   parameter logic [23:0] ROUND_TICKS  = 24'd12_500_000,
   parameter logic [23:0] FREEZE_TICKS = 24'd2_500_000,
   parameter logic [3:0]  WIN_SCORE    = 4'd9,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  wire logic clk,
   input  wire logic rst,
   round_arbiter_if.slave bus
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_ISSUE  = 3'd1;
   localparam logic [2:0] c_WAIT   = 3'd2;
   localparam logic [2:0] c_RESULT = 3'd3;
   localparam logic [2:0] c_OVER   = 3'd4;

   logic [2:0]  r_state;
   logic [7:0]  r_lfsr;
   logic [7:0]  r_value;
   logic [3:0]  r_score [4];
   logic [3:0]  r_ack;
   logic [1:0]  r_winner;
   logic        r_wv;
   logic        r_go;
   logic [1:0]  r_rr;
   logic [3:0]  r_lock;
   logic [23:0] r_timer;

   logic [7:0]  w_lfsr_nxt;
   logic [3:0]  w_elig;
   logic        w_gnt_vld;
   logic [1:0]  w_gnt_idx;
   logic [1:0]  w_cand;
   logic [3:0]  w_gnt_onehot;
   logic [7:0]  w_guess_sel;
   logic        w_correct;
   logic [3:0]  w_lock_nxt;
   logic        w_any_win;
   logic        w_round_tmo;
   logic        w_freeze_done;

   assign w_lfsr_nxt    = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   assign w_elig        = bus.guess_valid & ~r_lock;
   assign w_gnt_onehot  = 4'b0001 << w_gnt_idx;
   assign w_guess_sel   = bus.guess[{w_gnt_idx, 3'b000} +: 8];
   assign w_correct     = w_gnt_vld && (w_guess_sel == r_value);
   assign w_lock_nxt    = r_lock | (w_gnt_vld ? w_gnt_onehot : 4'b0000);
   assign w_round_tmo   = (r_timer == ROUND_TICKS - 24'd1);
   assign w_freeze_done = (r_timer == FREEZE_TICKS - 24'd1);
   assign w_any_win     = (r_score[0] >= WIN_SCORE) || (r_score[1] >= WIN_SCORE) ||
                          (r_score[2] >= WIN_SCORE) || (r_score[3] >= WIN_SCORE);

   // Search starts at the round-robin pointer and wraps; first eligible player wins the slot.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = 2'd0;
      w_cand    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         w_cand = r_rr + 2'(k);
         if (!w_gnt_vld && w_elig[w_cand]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= c_IDLE;
         r_lfsr   <= LFSR_SEED;
         r_value  <= 8'h00;
         for (int i = 0; i < 4; i++) r_score[i] <= 4'd0;
         r_ack    <= 4'b0000;
         r_winner <= 2'd0;
         r_wv     <= 1'b0;
         r_go     <= 1'b0;
         r_rr     <= 2'd0;
         r_lock   <= 4'b0000;
         r_timer  <= 24'd0;
      end else begin
         r_ack <= 4'b0000;
         case (r_state)
            c_IDLE: begin
               if (bus.start) r_state <= c_ISSUE;
            end
            c_ISSUE: begin
               r_lfsr  <= w_lfsr_nxt;
               r_value <= w_lfsr_nxt;
               r_timer <= 24'd0;
               r_lock  <= 4'b0000;
               r_wv    <= 1'b0;
               r_state <= c_WAIT;
            end
            c_WAIT: begin
               if (w_gnt_vld) begin
                  r_ack <= w_gnt_onehot;
                  r_rr  <= w_gnt_idx + 2'd1;
               end
               // A correct grant beats a simultaneous timeout.
               if (w_correct) begin
                  r_score[w_gnt_idx] <= (r_score[w_gnt_idx] == 4'hF) ? 4'hF
                                        : r_score[w_gnt_idx] + 4'd1;
                  r_winner <= w_gnt_idx;
                  r_wv     <= 1'b1;
                  r_timer  <= 24'd0;
                  r_state  <= c_RESULT;
               end else begin
                  r_lock <= w_lock_nxt;
                  if (w_round_tmo || (w_lock_nxt == 4'b1111)) begin
                     r_timer <= 24'd0;
                     r_state <= c_RESULT;
                  end else begin
                     r_timer <= r_timer + 24'd1;
                  end
               end
            end
            c_RESULT: begin
               if (w_freeze_done) begin
                  r_timer <= 24'd0;
                  r_wv    <= 1'b0;
                  r_go    <= w_any_win;
                  r_state <= w_any_win ? c_OVER : c_ISSUE;
               end else begin
                  r_timer <= r_timer + 24'd1;
               end
            end
            c_OVER: begin
               if (bus.start) begin
                  for (int i = 0; i < 4; i++) r_score[i] <= 4'd0;
                  r_go    <= 1'b0;
                  r_state <= c_ISSUE;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign bus.guess_ack    = r_ack;
   assign bus.value        = r_value;
   assign bus.p1           = {12'b0, r_score[0]};
   assign bus.p2           = {12'b0, r_score[1]};
   assign bus.p3           = {12'b0, r_score[2]};
   assign bus.p4           = {12'b0, r_score[3]};
   assign bus.winner       = r_winner;
   assign bus.winner_valid = r_wv;
   assign bus.game_over    = r_go;
   assign bus.state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_round_arbiter.sv
// tb_round_arbiter -- directed self-checking bench for round_arbiter.
// Rev 1.0
`default_nettype none

module tb_round_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   round_arbiter_if bus ();

   round_arbiter #(
      .ROUND_TICKS (24'd20),
      .FREEZE_TICKS(24'd4),
      .WIN_SCORE   (4'd2),
      .LFSR_SEED   (8'hA5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int n = 0;
      while (bus.state !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, {29'd0, bus.state}, {29'd0, s});
   endtask

   initial begin
      bus.start       = 1'b0;
      bus.guess_valid = 4'b0000;
      bus.guess       = 32'h0;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst_state", {29'd0, bus.state}, 32'd0);
      check("rst_value", {24'd0, bus.value}, 32'h00);
      check("rst_p1", {16'd0, bus.p1}, 32'd0);
      check("rst_p2", {16'd0, bus.p2}, 32'd0);
      check("rst_p3", {16'd0, bus.p3}, 32'd0);
      check("rst_p4", {16'd0, bus.p4}, 32'd0);
      check("rst_ack", {28'd0, bus.guess_ack}, 32'd0);
      check("rst_winner", {30'd0, bus.winner}, 32'd0);
      check("rst_wv", {31'd0, bus.winner_valid}, 32'd0);
      check("rst_go", {31'd0, bus.game_over}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("idle_hold", {29'd0, bus.state}, 32'd0);

      // Start: ISSUE then WAIT with first LFSR step A5 -> 4A
      bus.start = 1'b1;
      @(negedge clk);
      check("t1_issue", {29'd0, bus.state}, 32'd1);
      bus.start = 1'b0;
      @(negedge clk);
      check("t1_wait", {29'd0, bus.state}, 32'd2);
      check("t1_value", {24'd0, bus.value}, 32'h4A);

      // Player 2 answers correctly
      bus.guess_valid = 4'b0100;
      bus.guess       = 32'h004A_0000;
      @(negedge clk);
      check("t2_ack", {28'd0, bus.guess_ack}, 32'b0100);
      check("t2_p3", {16'd0, bus.p3}, 32'h0001);
      check("t2_winner", {30'd0, bus.winner}, 32'd2);
      check("t2_wv", {31'd0, bus.winner_valid}, 32'd1);
      check("t2_result", {29'd0, bus.state}, 32'd3);
      bus.guess_valid = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_hold_state", {29'd0, bus.state}, 32'd3);
         check("t2_hold_wv", {31'd0, bus.winner_valid}, 32'd1);
         check("t2_hold_ack", {28'd0, bus.guess_ack}, 32'd0);
      end
      @(negedge clk);
      check("t2_reissue", {29'd0, bus.state}, 32'd1);
      check("t2_wv_clr", {31'd0, bus.winner_valid}, 32'd0);
      @(negedge clk);
      check("t2_wait", {29'd0, bus.state}, 32'd2);
      // 4A = 0100_1010, taps b7^b5^b4^b3 = 1 -> 1001_0101
      check("t2_value", {24'd0, bus.value}, 32'h95);

      // All four request, rr_ptr=3, only player 1 right: grants 3, 0, 1
      bus.guess_valid = 4'b1111;
      bus.guess       = 32'h0000_9500;
      @(negedge clk);
      check("t3_ack3", {28'd0, bus.guess_ack}, 32'b1000);
      check("t3_still_wait", {29'd0, bus.state}, 32'd2);
      @(negedge clk);
      check("t3_ack0", {28'd0, bus.guess_ack}, 32'b0001);
      @(negedge clk);
      check("t3_ack1", {28'd0, bus.guess_ack}, 32'b0010);
      check("t3_result", {29'd0, bus.state}, 32'd3);
      check("t3_winner", {30'd0, bus.winner}, 32'd1);
      check("t3_p2", {16'd0, bus.p2}, 32'h0001);
      check("t3_p3", {16'd0, bus.p3}, 32'h0001);
      check("t3_p1", {16'd0, bus.p1}, 32'h0000);
      bus.guess_valid = 4'b0000;
      @(negedge clk);
      check("t3_ack_none", {28'd0, bus.guess_ack}, 32'd0);
      wait_state(3'd1, 6, "t3_reissue");
      @(negedge clk);
      check("t3_wait", {29'd0, bus.state}, 32'd2);
      check("t3_value", {24'd0, bus.value}, 32'h2A);

      // No guesses: RESULT exactly 20 cycles after WAIT entry
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         check("t4_in_wait", {29'd0, bus.state}, 32'd2);
      end
      @(negedge clk);
      check("t4_timeout", {29'd0, bus.state}, 32'd3);
      check("t4_wv", {31'd0, bus.winner_valid}, 32'd0);
      check("t4_p1", {16'd0, bus.p1}, 32'h0000);
      check("t4_p2", {16'd0, bus.p2}, 32'h0001);
      check("t4_p3", {16'd0, bus.p3}, 32'h0001);
      check("t4_p4", {16'd0, bus.p4}, 32'h0000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_hold", {29'd0, bus.state}, 32'd3);
      end
      @(negedge clk);
      check("t4_reissue", {29'd0, bus.state}, 32'd1);
      @(negedge clk);
      check("t4_value", {24'd0, bus.value}, 32'h54);

      // Player 0 wins two rounds -> OVER
      bus.guess_valid = 4'b0001;
      bus.guess       = 32'h0000_0054;
      @(negedge clk);
      check("t5_ack_a", {28'd0, bus.guess_ack}, 32'b0001);
      check("t5_p1_a", {16'd0, bus.p1}, 32'h0001);
      check("t5_winner", {30'd0, bus.winner}, 32'd0);
      bus.guess_valid = 4'b0000;
      wait_state(3'd2, 8, "t5_wait_b");
      check("t5_value_b", {24'd0, bus.value}, 32'hA9);
      bus.guess_valid = 4'b0001;
      bus.guess       = 32'h0000_00A9;
      @(negedge clk);
      check("t5_p1_b", {16'd0, bus.p1}, 32'h0002);
      check("t5_result", {29'd0, bus.state}, 32'd3);
      bus.guess_valid = 4'b0000;
      wait_state(3'd4, 8, "t5_over");
      check("t5_go", {31'd0, bus.game_over}, 32'd1);
      check("t5_p1_over", {16'd0, bus.p1}, 32'h0002);
      check("t5_value_held", {24'd0, bus.value}, 32'hA9);
      @(negedge clk);
      check("t5_over_hold", {29'd0, bus.state}, 32'd4);
      bus.start = 1'b1;
      @(negedge clk);
      check("t5_restart", {29'd0, bus.state}, 32'd1);
      check("t5_p1_clr", {16'd0, bus.p1}, 32'd0);
      check("t5_p2_clr", {16'd0, bus.p2}, 32'd0);
      check("t5_p3_clr", {16'd0, bus.p3}, 32'd0);
      check("t5_go_clr", {31'd0, bus.game_over}, 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      check("t5_new_wait", {29'd0, bus.state}, 32'd2);
      check("t5_new_value", {24'd0, bus.value}, 32'h53);

      // Async reset with a correct guess pending, checked before the next edge
      bus.guess_valid = 4'b0001;
      bus.guess       = 32'h0000_0053;
      #2;
      rst = 1'b0;
      #1;
      check("t6_state", {29'd0, bus.state}, 32'd0);
      check("t6_value", {24'd0, bus.value}, 32'h00);
      check("t6_ack", {28'd0, bus.guess_ack}, 32'd0);
      check("t6_p1", {16'd0, bus.p1}, 32'd0);
      check("t6_wv", {31'd0, bus.winner_valid}, 32'd0);
      check("t6_go", {31'd0, bus.game_over}, 32'd0);
      check("t6_winner", {30'd0, bus.winner}, 32'd0);
      @(posedge clk);
      #1;
      check("t6_hold_state", {29'd0, bus.state}, 32'd0);
      check("t6_hold_p1", {16'd0, bus.p1}, 32'd0);
      check("t6_hold_ack", {28'd0, bus.guess_ack}, 32'd0);
      bus.guess_valid = 4'b0000;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_idle", {29'd0, bus.state}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
